// File: rtl/sw_debounce.sv
// sw_debounce
// Debounces a bank of slow mechanical switches. Each raw input is brought
// into the clock domain with a two-flop synchronizer. It is then sampled
// only on prescaler ticks. A new level is accepted once it has disagreed
// with the current debounced level on STABLE_CNT consecutive ticks.
// Accepted changes also produce one-cycle edge pulses.
//
// Ports
//   clk      : single clock, everything updates on its rising edge
//   rst      : synchronous active-high reset
//   sw_raw   : asynchronous raw switch levels (WIDTH bits)
//   sw_db    : debounced levels (bits [7:0] -> encoder x, bit 8 -> en)
//   sw_rise  : one-cycle pulse per bit on an accepted 0->1 change
//   sw_fall  : one-cycle pulse per bit on an accepted 1->0 change
//   changed  : one-cycle pulse whenever any rise or fall pulse is high
module sw_debounce #(
   parameter int WIDTH      = 9,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             changed
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W  = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CNT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic {
      IDLE,
      PENDING
   } bitStateT;

   logic [WIDTH-1:0]  syncMeta;
   logic [WIDTH-1:0]  syncOut;
   logic [TICK_W-1:0] tickCnt;
   logic              tick;
   logic [WIDTH-1:0]  mismatch;
   logic [WIDTH-1:0]  acceptVec;
   bitStateT          bitState [WIDTH];
   logic [CNT_W-1:0]  bitCnt   [WIDTH];

   // Two-stage synchronizer. Only the second stage is ever looked at, so a
   // metastable first stage has a full cycle to settle before it is used.
   always_ff @(posedge clk) begin
      if (rst) begin
         syncMeta <= '0;
         syncOut  <= '0;
      end else begin
         syncMeta <= sw_raw;
         syncOut  <= syncMeta;
      end
   end

   // Sample-rate prescaler. It wraps after TICK_DIV cycles. tick is high during
   // the last count, so the first tick after reset lands TICK_DIV cycles later.
   // With TICK_DIV=1 the counter stays at 0 and tick is permanently high.
   always_ff @(posedge clk) begin
      if (rst) begin
         tickCnt <= '0;
      end else if (tick) begin
         tickCnt <= '0;
      end else begin
         tickCnt <= tickCnt + TICK_W'(1);
      end
   end

   assign tick     = (tickCnt == TICK_LAST);
   assign mismatch = syncOut ^ sw_db;

   // A bit is accepted on a tick when the level disagrees with the debounced
   // value for the STABLE_CNT-th time in a row. With STABLE_CNT=1 the first
   // disagreeing tick is enough, so IDLE can accept directly. Otherwise the
   // bit must already be PENDING with its counter at the last step.
   always_comb begin
      acceptVec = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (tick && mismatch[i]) begin
            if (STABLE_CNT == 1) begin
               acceptVec[i] = 1'b1;
            end else if (bitState[i] == PENDING && bitCnt[i] == CNT_LAST) begin
               acceptVec[i] = 1'b1;
            end
         end
      end
   end

   // Per-bit IDLE/PENDING tracker and registered outputs. Between ticks
   // nothing moves, so sync activity between samples is invisible. If a tick
   // sees agreement while PENDING, the run is discarded as a glitch. Because
   // an accepted bit flips sw_db, its rise and fall pulses can never both be
   // high. Bits that were not accepted get no pulse at all.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_db   <= '0;
         sw_rise <= '0;
         sw_fall <= '0;
         changed <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            bitState[i] <= IDLE;
            bitCnt[i]   <= '0;
         end
      end else begin
         sw_db   <= sw_db ^ acceptVec;
         sw_rise <= acceptVec & syncOut;
         sw_fall <= acceptVec & ~syncOut;
         changed <= |acceptVec;
         for (int i = 0; i < WIDTH; i++) begin
            if (tick) begin
               case (bitState[i])
                  IDLE: begin
                     if (mismatch[i] && !acceptVec[i]) begin
                        bitState[i] <= PENDING;
                        bitCnt[i]   <= CNT_ONE;
                     end else begin
                        bitCnt[i]   <= '0;
                     end
                  end
                  PENDING: begin
                     if (!mismatch[i] || acceptVec[i]) begin
                        bitState[i] <= IDLE;
                        bitCnt[i]   <= '0;
                     end else begin
                        bitCnt[i]   <= bitCnt[i] + CNT_ONE;
                     end
                  end
                  default: begin
                     bitState[i] <= IDLE;
                     bitCnt[i]   <= '0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce
// Directed bench for sw_debounce with TICK_DIV=4 and STABLE_CNT=3.
// A behavioural model tracks the expected outputs every cycle. It holds the
// sampled levels, a tick derived from the cycle count since reset, and a
// run length of disagreeing samples per bit. Hand-computed literals pin the
// model at the interesting points.
module tb_sw_debounce;

   localparam int WIDTH      = 9;
   localparam int TICK_DIV   = 4;
   localparam int STABLE_CNT = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] sw_raw = '0;
   logic [WIDTH-1:0] sw_db;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic             changed;

   int assertCount = 0;
   int failCount   = 0;

   bit               modelValid = 1'b0;
   logic [WIDTH-1:0] modelStage1 = '0;
   logic [WIDTH-1:0] modelStage2 = '0;
   int               modelCycle = 0;
   bit               modelTick;
   int               runLen [WIDTH];
   logic [WIDTH-1:0] expDb = '0;
   logic [WIDTH-1:0] expRise = '0;
   logic [WIDTH-1:0] expFall = '0;
   logic             expChanged = 1'b0;

   int               changedCount = 0;
   logic [WIDTH-1:0] riseAcc = '0;
   logic [WIDTH-1:0] fallAcc = '0;
   int               lat;

   sw_debounce #(
      .WIDTH     (WIDTH),
      .TICK_DIV  (TICK_DIV),
      .STABLE_CNT(STABLE_CNT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .sw_raw (sw_raw),
      .sw_db  (sw_db),
      .sw_rise(sw_rise),
      .sw_fall(sw_fall),
      .changed(changed)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Single comparison point. Every check goes through here, so it bumps the
   // counters that the summary line reports.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                  name, actual, expected, $time);
      end
   endtask

   // Drive a raw level at a falling edge and hold it for a number of cycles.
   task automatic applyStimulus(input logic [WIDTH-1:0] value, input int holdCycles);
      sw_raw = value;
      repeat (holdCycles) @(negedge clk);
   endtask

   // Clear the pulse accumulators before a scenario.
   task automatic clearAcc();
      changedCount = 0;
      riseAcc      = '0;
      fallAcc      = '0;
   endtask

   // Behavioural model, stepped once per rising edge.
   // The raw input reaches the sampler two edges later. A tick happens on
   // every TICK_DIV-th cycle after reset. A bit flips once STABLE_CNT
   // consecutive ticks have seen it differ from the debounced value.
   always @(posedge clk) begin
      if (rst) begin
         modelValid  = 1'b1;
         modelStage1 = '0;
         modelStage2 = '0;
         modelCycle  = 0;
         expDb       = '0;
         expRise     = '0;
         expFall     = '0;
         expChanged  = 1'b0;
         for (int b = 0; b < WIDTH; b++) runLen[b] = 0;
      end else begin
         modelTick  = ((modelCycle % TICK_DIV) == TICK_DIV - 1);
         modelCycle = modelCycle + 1;
         expRise    = '0;
         expFall    = '0;
         if (modelTick) begin
            for (int b = 0; b < WIDTH; b++) begin
               if (modelStage2[b] != expDb[b]) begin
                  runLen[b] = runLen[b] + 1;
                  if (runLen[b] == STABLE_CNT) begin
                     runLen[b] = 0;
                     if (modelStage2[b]) expRise[b] = 1'b1;
                     else                expFall[b] = 1'b1;
                  end
               end else begin
                  runLen[b] = 0;
               end
            end
         end
         expDb       = expDb ^ expRise ^ expFall;
         expChanged  = |(expRise | expFall);
         modelStage2 = modelStage1;
         modelStage1 = sw_raw;
      end
   end

   // Cycle-by-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("model sw_db",   32'(sw_db),   32'(expDb));
         checkOutput("model sw_rise", 32'(sw_rise), 32'(expRise));
         checkOutput("model sw_fall", 32'(sw_fall), 32'(expFall));
         checkOutput("model changed", 32'(changed), 32'(expChanged));
      end
   end

   // Pulse accumulators used by the directed checks, sampled just after the edge.
   always @(posedge clk) begin
      #1;
      if (changed === 1'b1) changedCount++;
      riseAcc = riseAcc | sw_rise;
      fallAcc = fallAcc | sw_fall;
   end

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios.
   initial begin
      rst    = 1'b1;
      sw_raw = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset sw_db",   32'(sw_db),   32'h0);
      checkOutput("reset sw_rise", 32'(sw_rise), 32'h0);
      checkOutput("reset sw_fall", 32'(sw_fall), 32'h0);
      checkOutput("reset changed", 32'(changed), 32'h0);

      $display("[TB] clean press");
      clearAcc();
      rst    = 1'b0;
      sw_raw = 9'h001;
      lat    = 0;
      while (sw_db !== 9'h001 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("press latency", 32'(lat), 32'd12);
      repeat (3) @(negedge clk);
      checkOutput("press sw_db",    32'(sw_db),        32'h001);
      checkOutput("press rise acc", 32'(riseAcc),      32'h001);
      checkOutput("press fall acc", 32'(fallAcc),      32'h000);
      checkOutput("press changed",  32'(changedCount), 32'd1);

      applyStimulus(9'h000, 20);

      $display("[TB] bounce");
      clearAcc();
      for (int c = 0; c < 40; c++) begin
         sw_raw = (((c / 3) % 2) == 0) ? 9'h001 : 9'h000;
         @(negedge clk);
      end
      applyStimulus(9'h000, 20);
      checkOutput("bounce sw_db",   32'(sw_db),        32'h000);
      checkOutput("bounce changed", 32'(changedCount), 32'd0);

      $display("[TB] short glitch");
      clearAcc();
      applyStimulus(9'h100, 2);
      applyStimulus(9'h000, 20);
      checkOutput("glitch sw_db",   32'(sw_db),        32'h000);
      checkOutput("glitch changed", 32'(changedCount), 32'd0);

      $display("[TB] multi-bit change");
      clearAcc();
      applyStimulus(9'h1A5, 20);
      checkOutput("multi sw_db",    32'(sw_db),        32'h1A5);
      checkOutput("multi rise acc", 32'(riseAcc),      32'h1A5);
      checkOutput("multi fall acc", 32'(fallAcc),      32'h000);
      checkOutput("multi changed",  32'(changedCount), 32'd1);

      $display("[TB] release");
      applyStimulus(9'h0FF, 20);
      clearAcc();
      applyStimulus(9'h07F, 20);
      checkOutput("release sw_db",    32'(sw_db),        32'h07F);
      checkOutput("release fall acc", 32'(fallAcc),      32'h080);
      checkOutput("release rise acc", 32'(riseAcc),      32'h000);
      checkOutput("release changed",  32'(changedCount), 32'd1);

      $display("[TB] reset mid-pending");
      applyStimulus(9'h000, 20);
      applyStimulus(9'h001, 6);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst sw_db",   32'(sw_db),   32'h0);
      checkOutput("midrst sw_rise", 32'(sw_rise), 32'h0);
      checkOutput("midrst sw_fall", 32'(sw_fall), 32'h0);
      checkOutput("midrst changed", 32'(changed), 32'h0);
      rst = 1'b0;
      repeat (11) @(negedge clk);
      checkOutput("midrst early sw_db", 32'(sw_db), 32'h000);
      @(negedge clk);
      checkOutput("midrst accept sw_db", 32'(sw_db), 32'h001);
      repeat (4) @(negedge clk);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
